bus_xbar_dec: RTL and testbench

Parametrised successor to the fixed five-device system bus. It decodes one CPU master port onto NUM_SLAVES peripheral ports (GPU, BIOS, UART, PS2, timer and future devices). Each access is registered, and each access has a bounded duration set by a timeout counter. Unmapped, illegal or timed-out accesses complete with an error word instead of hanging the CPU, and they latch an error interrupt for the interrupt controller.

---
 rtl/bus_xbar_dec.sv | 177 +++++++++++++++++
 tb/tb_bus_xbar_dec.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xbar_dec.sv
// bus_xbar_dec: decodes one CPU master port onto NUM_SLAVES peripheral ports.
// Every access is registered and bounded by a timeout counter. Unmapped,
// illegal or timed-out accesses complete with ERR_DATA and latch a sticky
// error interrupt together with the failing address.
module bus_xbar_dec #(
  parameter int          NUM_SLAVES = 5,
  parameter logic [3:0]  BASE_TAG   = 4'hC,
  parameter int          DEC_LO     = 12,
  parameter int          TIMEOUT    = 256,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  // master side
  input  logic [31:0]              m_addr_i,
  input  logic [31:0]              m_data_i,
  input  logic [1:0]               m_sel_i,
  input  logic                     m_rd_i,
  input  logic                     m_we_i,
  output logic [31:0]              m_data_o,
  output logic                     m_ack_o,
  // shared slave side
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_data_o,
  output logic [1:0]               s_sel_o,
  output logic [NUM_SLAVES-1:0]    s_rd_o,
  output logic [NUM_SLAVES-1:0]    s_we_o,
  input  logic [NUM_SLAVES*32-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  // error reporting
  output logic                     err_irq,
  output logic [31:0]              err_addr,
  input  logic                     err_clr_i
);

  localparam int               CNT_W        = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       NUM_SLAVES_W = 5'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;       // cycles spent in ACCESS for the current request
  logic [3:0]       idx;       // slave index captured with the request
  logic             is_write;  // captured request direction

  // Request decode, taken straight from the master inputs while in IDLE.
  logic [3:0]            req_idx;
  logic                  req_illegal;
  logic [NUM_SLAVES-1:0] req_onehot;

  // Read data and ack of the slave selected by the captured index.
  logic [31:0]           sel_rdata;
  logic                  sel_ack;

  assign req_idx = m_addr_i[DEC_LO+3:DEC_LO];

  // Classify the incoming request and build its one-hot strobe pattern.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    req_onehot  = '0;
    req_illegal = (m_rd_i & m_we_i)
                | (m_addr_i[31:28] != BASE_TAG)
                | ({1'b0, req_idx} >= NUM_SLAVES_W);
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot[k] = (req_idx == 4'(k));
    end
  end

  // Select the addressed slave's ack and read data; other slaves are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx == 4'(k)) begin
        sel_rdata = s_data_i[32*k +: 32];
        sel_ack   = s_ack_i[k];
      end
    end
  end

  // Access sequencer: IDLE -> ACCESS/ERROR -> DONE -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the reset is asynchronous so strobes fall the moment rstn drops,
    // even in the middle of an access, without waiting for a clock edge.
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      is_write <= 1'b0;
      m_data_o <= '0;
      m_ack_o  <= 1'b0;
      s_addr_o <= '0;
      s_data_o <= '0;
      s_sel_o  <= '0;
      s_rd_o   <= '0;
      s_we_o   <= '0;
      err_irq  <= 1'b0;
      err_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // right-hand side reads the value from before this clock edge.
      m_ack_o <= 1'b0;

      // Clear first; the set in ERROR below is a later assignment to the
      // same register and therefore wins when both happen in one cycle.
      if (err_clr_i) begin
        err_irq <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (m_rd_i | m_we_i) begin
            s_addr_o <= m_addr_i;
            s_data_o <= m_data_i;
            s_sel_o  <= m_sel_i;
            idx      <= req_idx;
            is_write <= m_we_i;
            if (req_illegal) begin
              state <= ERROR;
            end else begin
              state <= ACCESS;
              cnt   <= '0;
              if (m_we_i) begin
                s_we_o <= req_onehot;
              end else begin
                s_rd_o <= req_onehot;
              end
            end
          end
        end

        ACCESS: begin
          // Saturate rather than wrap; the timeout exit fires well before.
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          if (sel_ack) begin
            m_data_o <= is_write ? 32'h0 : sel_rdata;
            m_ack_o  <= 1'b1;
            s_rd_o   <= '0;
            s_we_o   <= '0;
            state    <= DONE;
          end else if (cnt == CNT_LAST) begin
            s_rd_o <= '0;
            s_we_o <= '0;
            state  <= ERROR;
          end
        end

        ERROR: begin
          m_data_o <= ERR_DATA;
          m_ack_o  <= 1'b1;
          err_addr <= s_addr_o;
          err_irq  <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          // The master sees m_ack_o this cycle and drops its request.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xbar_dec.sv
// Directed testbench for bus_xbar_dec with the default parameter set
// (5 slaves, tag 4'hC, index at addr[15:12], TIMEOUT 256).
module tb_bus_xbar_dec;

  localparam int NS = 5;

  logic              clk;
  logic              rstn;
  logic [31:0]       m_addr_i;
  logic [31:0]       m_data_i;
  logic [1:0]        m_sel_i;
  logic              m_rd_i;
  logic              m_we_i;
  logic [31:0]       m_data_o;
  logic              m_ack_o;
  logic [31:0]       s_addr_o;
  logic [31:0]       s_data_o;
  logic [1:0]        s_sel_o;
  logic [NS-1:0]     s_rd_o;
  logic [NS-1:0]     s_we_o;
  logic [NS*32-1:0]  s_data_i;
  logic [NS-1:0]     s_ack_i;
  logic              err_irq;
  logic [31:0]       err_addr;
  logic              err_clr_i;

  int checks;
  int errors;

  bus_xbar_dec dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_addr_i  (m_addr_i),
    .m_data_i  (m_data_i),
    .m_sel_i   (m_sel_i),
    .m_rd_i    (m_rd_i),
    .m_we_i    (m_we_i),
    .m_data_o  (m_data_o),
    .m_ack_o   (m_ack_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_sel_o   (s_sel_o),
    .s_rd_o    (s_rd_o),
    .s_we_o    (s_we_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i),
    .err_irq   (err_irq),
    .err_addr  (err_addr),
    .err_clr_i (err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One master access with a slave model. The request is driven at a falling
  // edge (cycle 0); cycle n is the n-th falling edge after that. The selected
  // slave acks on its ack_after-th strobe cycle (0 = never); 'noise' slaves
  // assert ack on every strobe cycle and must be ignored.
  task automatic run_access(input  logic [31:0] addr,
                            input  logic [31:0] wdata,
                            input  logic        rd,
                            input  logic        we,
                            input  int          ack_after,
                            input  int          ack_slave,
                            input  logic [31:0] rdata,
                            input  logic [NS-1:0] noise,
                            output int          strobe_cycles,
                            output logic [NS-1:0] strobe_or,
                            output int          ack_cycle,
                            output int          ack_pulses,
                            output logic [31:0] got_rdata,
                            output logic [31:0] got_sdata);
    strobe_cycles = 0;
    strobe_or     = '0;
    ack_cycle     = 0;
    ack_pulses    = 0;
    got_rdata     = '0;
    got_sdata     = '0;
    @(negedge clk);
    m_addr_i = addr;
    m_data_i = wdata;
    m_sel_i  = 2'b10;
    m_rd_i   = rd;
    m_we_i   = we;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      s_ack_i = '0;
      if ((s_rd_o | s_we_o) != '0) begin
        strobe_cycles++;
        strobe_or |= (s_rd_o | s_we_o);
        got_sdata  = s_data_o;
        s_ack_i    = noise;
        if (ack_after != 0 && strobe_cycles == ack_after) begin
          s_ack_i[ack_slave] = 1'b1;
          s_data_i[32*ack_slave +: 32] = rdata;
        end
      end
      if (m_ack_o) begin
        ack_pulses++;
        if (ack_cycle == 0) begin
          ack_cycle = n;
          got_rdata = m_data_o;
          m_rd_i    = 1'b0;
          m_we_i    = 1'b0;
        end
      end
      if (ack_cycle != 0 && n >= ack_cycle + 3) break;
    end
    s_ack_i = '0;
    m_rd_i  = 1'b0;
    m_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    m_addr_i  = '0;
    m_data_i  = '0;
    m_sel_i   = '0;
    m_rd_i    = 1'b0;
    m_we_i    = 1'b0;
    s_data_i  = '0;
    s_ack_i   = '0;
    err_clr_i = 1'b0;
    #3;
    checks++;
    if ({m_data_o, m_ack_o, s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o, err_irq, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: m_data=%h ack=%b s_addr=%h s_data=%h sel=%b rd=%b we=%b irq=%b err_addr=%h, required all zero",
               m_data_o, m_ack_o, s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o, err_irq, err_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_read_slave2();
    int sc, ac, ap;
    logic [NS-1:0] so;
    logic [31:0] rd, sd;
    run_access(32'hC000_2004, 32'h0, 1'b1, 1'b0, 3, 2, 32'h1234_5678, 5'b10011,
               sc, so, ac, ap, rd, sd);
    checks++;
    if (so !== 5'b00100) begin errors++; $display("FAIL rd2_strobe: got %b required 00100", so); end
    checks++;
    if (sc !== 3) begin errors++; $display("FAIL rd2_strobe_len: got %0d required 3", sc); end
    checks++;
    if (ac !== 4) begin errors++; $display("FAIL rd2_ack_cycle: got %0d required 4", ac); end
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd2_data: got %h required 12345678", rd); end
    checks++;
    if (ap !== 1) begin errors++; $display("FAIL rd2_ack_pulses: got %0d required 1", ap); end
    checks++;
    if (err_irq !== 1'b0) begin errors++; $display("FAIL rd2_irq: got %b required 0", err_irq); end
    checks++;
    if (s_addr_o !== 32'hC000_2004) begin errors++; $display("FAIL rd2_s_addr: got %h required c0002004", s_addr_o); end
  endtask

  task automatic test_write_slave0();
    int sc, ac, ap;
    logic [NS-1:0] so;
    logic [31:0] rd, sd;
    run_access(32'hC000_0010, 32'hA5A5_0001, 1'b0, 1'b1, 1, 0, 32'h7777_7777, 5'b00000,
               sc, so, ac, ap, rd, sd);
    checks++;
    if (so !== 5'b00001) begin errors++; $display("FAIL wr0_strobe: got %b required 00001", so); end
    checks++;
    if (s_rd_o !== 5'b0 || sc !== 1) begin errors++; $display("FAIL wr0_strobe_len: got %0d rd=%b required 1 rd=0", sc, s_rd_o); end
    checks++;
    if (sd !== 32'hA5A5_0001) begin errors++; $display("FAIL wr0_s_data: got %h required a5a50001", sd); end
    checks++;
    if (ac !== 2) begin errors++; $display("FAIL wr0_ack_cycle: got %0d required 2", ac); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL wr0_m_data: got %h required 00000000", rd); end
    checks++;
    if (s_sel_o !== 2'b10) begin errors++; $display("FAIL wr0_sel: got %b required 10", s_sel_o); end
  endtask

  task automatic test_illegal();
    int sc, ac, ap;
    logic [NS-1:0] so;
    logic [31:0] rd, sd;
    run_access(32'hC000_7000, 32'h0, 1'b1, 1'b0, 1, 0, 32'h0, 5'b00000,
               sc, so, ac, ap, rd, sd);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL idx7_no_strobe: got %0d strobe cycles required 0", sc); end
    checks++;
    if (rd !== 32'hDEAD_BEEF || ac !== 2) begin errors++; $display("FAIL idx7_err: got data %h cycle %0d required deadbeef cycle 2", rd, ac); end
    checks++;
    if (err_irq !== 1'b1 || err_addr !== 32'hC000_7000) begin errors++; $display("FAIL idx7_irq: got irq %b addr %h required 1 c0007000", err_irq, err_addr); end
    run_access(32'h8000_0000, 32'h0, 1'b1, 1'b0, 1, 0, 32'h0, 5'b00000,
               sc, so, ac, ap, rd, sd);
    checks++;
    if (sc !== 0 || ap !== 1) begin errors++; $display("FAIL tag_no_strobe: got %0d strobes %0d acks required 0 and 1", sc, ap); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tag_err_data: got %h required deadbeef", rd); end
    checks++;
    if (err_irq !== 1'b1 || err_addr !== 32'h8000_0000) begin errors++; $display("FAIL tag_err_addr: got irq %b addr %h required 1 80000000", err_irq, err_addr); end
  endtask

  task automatic clear_irq(input string name);
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    checks++;
    if (err_irq !== 1'b0) begin errors++; $display("FAIL %s: got irq %b required 0", name, err_irq); end
  endtask

  // rd and we together is illegal; err_clr_i high in the ERROR cycle loses.
  task automatic test_set_beats_clear();
    clear_irq("pre_clear");
    @(negedge clk);
    m_addr_i = 32'hC000_0000;
    m_rd_i   = 1'b1;
    m_we_i   = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b1;
    checks++;
    if ((s_rd_o | s_we_o) !== 5'b0) begin errors++; $display("FAIL rdwe_no_strobe: got rd %b we %b required 0", s_rd_o, s_we_o); end
    @(negedge clk);
    err_clr_i = 1'b0;
    m_rd_i    = 1'b0;
    m_we_i    = 1'b0;
    checks++;
    if (m_ack_o !== 1'b1 || m_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdwe_err: got ack %b data %h required 1 deadbeef", m_ack_o, m_data_o); end
    checks++;
    if (err_irq !== 1'b1 || err_addr !== 32'hC000_0000) begin errors++; $display("FAIL set_wins: got irq %b addr %h required 1 c0000000", err_irq, err_addr); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int sc, ac, ap;
    logic [NS-1:0] so;
    logic [31:0] rd, sd;
    clear_irq("pre_timeout_clear");
    run_access(32'hC000_4000, 32'h0, 1'b1, 1'b0, 0, 4, 32'h0, 5'b00000,
               sc, so, ac, ap, rd, sd);
    checks++;
    if (so !== 5'b10000 || sc !== 256) begin errors++; $display("FAIL to_strobe: got %b for %0d cycles required 10000 for 256", so, sc); end
    checks++;
    if (ac !== 258 || ap !== 1) begin errors++; $display("FAIL to_ack: got cycle %0d pulses %0d required 258 and 1", ac, ap); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_data: got %h required deadbeef", rd); end
    checks++;
    if (err_irq !== 1'b1 || err_addr !== 32'hC000_4000) begin errors++; $display("FAIL to_irq: got irq %b addr %h required 1 c0004000", err_irq, err_addr); end
    clear_irq("to_clear");
    checks++;
    if (err_addr !== 32'hC000_4000) begin errors++; $display("FAIL to_addr_kept: got %h required c0004000", err_addr); end
  endtask

  task automatic test_ack_at_timeout();
    int sc, ac, ap;
    logic [NS-1:0] so;
    logic [31:0] rd, sd;
    run_access(32'hC000_3000, 32'h0, 1'b1, 1'b0, 256, 3, 32'h5555_AAAA, 5'b00000,
               sc, so, ac, ap, rd, sd);
    checks++;
    if (sc !== 256 || ac !== 257) begin errors++; $display("FAIL late_ack_timing: got %0d strobes ack cycle %0d required 256 and 257", sc, ac); end
    checks++;
    if (rd !== 32'h5555_AAAA) begin errors++; $display("FAIL late_ack_data: got %h required 5555aaaa", rd); end
    checks++;
    if (err_irq !== 1'b0 || ap !== 1) begin errors++; $display("FAIL late_ack_irq: got irq %b pulses %0d required 0 and 1", err_irq, ap); end
  endtask

  task automatic test_reset_mid_access();
    int sc, ac, ap;
    logic [NS-1:0] so;
    logic [31:0] rd, sd;
    @(negedge clk);
    m_addr_i = 32'hC000_1000;
    m_rd_i   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_rd_o !== 5'b00010) begin errors++; $display("FAIL mid_strobe: got %b required 00010", s_rd_o); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (s_rd_o !== 5'b0 || m_ack_o !== 1'b0 || s_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got rd %b ack %b s_addr %h required 0 0 0", s_rd_o, m_ack_o, s_addr_o);
    end
    m_rd_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_access(32'hC000_3008, 32'h0, 1'b1, 1'b0, 2, 3, 32'h0BAD_F00D, 5'b00000,
               sc, so, ac, ap, rd, sd);
    checks++;
    if (so !== 5'b01000 || sc !== 2 || ac !== 3) begin errors++; $display("FAIL post_reset_timing: got %b %0d strobes ack cycle %0d required 01000 2 3", so, sc, ac); end
    checks++;
    if (rd !== 32'h0BAD_F00D || err_irq !== 1'b0) begin errors++; $display("FAIL post_reset_read: got %h irq %b required 0badf00d 0", rd, err_irq); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_slave2();
    test_write_slave0();
    test_illegal();
    test_set_beats_clear();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
